// File: rtl/ro_puf_pkg.sv
// Shared types for the ring-oscillator count-pair front end.
package ro_puf_pkg;

   localparam int CNT_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      COUNT  = 2'd2,
      DONE   = 2'd3
   } state_e;

endpackage

// File: rtl/ro_edge_counter.sv
// One oscillator channel: synchronizer, rising-edge detect and a saturating edge counter.
module ro_edge_counter #(
   parameter int CNT_W       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ro_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   rise;

   assign rise  = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign cnt_o = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ro_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // Saturate instead of wrapping so a fast oscillator never reads as slow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && rise && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/ro_count_pair.sv
// Measurement sequencer: enables two oscillators, counts their edges over a fixed window,
// and presents the count pair with a one-cycle valid strobe.
module ro_count_pair
   import ro_puf_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int WINDOW      = 1024,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             ro_a,
   input  logic             ro_b,
   output logic             ro_en,
   output logic             busy,
   output logic [CNT_W-1:0] count1,
   output logic [CNT_W-1:0] count2,
   output logic             count_valid
);

   localparam int TMR_W = $clog2(WINDOW + SYNC_STAGES + 1);

   state_e           state_q;
   logic [TMR_W-1:0] tmr_q;
   logic             ro_en_q;
   logic             busy_q;
   logic             valid_q;
   logic [CNT_W-1:0] cnt1_q;
   logic [CNT_W-1:0] cnt2_q;
   logic [CNT_W-1:0] a_cnt;
   logic [CNT_W-1:0] b_cnt;
   logic             clr;
   logic             en;

   assign clr = (state_q == IDLE) && start;
   assign en  = (state_q == COUNT);

   ro_edge_counter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_cnt_a (
      .clk   (clk),
      .rst_n (rst_n),
      .ro_i  (ro_a),
      .clr_i (clr),
      .en_i  (en),
      .cnt_o (a_cnt)
   );

   ro_edge_counter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_cnt_b (
      .clk   (clk),
      .rst_n (rst_n),
      .ro_i  (ro_b),
      .clr_i (clr),
      .en_i  (en),
      .cnt_o (b_cnt)
   );

   // Outputs are registered alongside the state, so each one reflects the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         ro_en_q <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         cnt1_q  <= '0;
         cnt2_q  <= '0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               tmr_q <= '0;
               if (start) begin
                  state_q <= SETTLE;
                  ro_en_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            SETTLE: begin
               // SYNC_STAGES+1 cycles flush whatever the synchronizers held before enable.
               if (tmr_q == TMR_W'(SYNC_STAGES)) begin
                  state_q <= COUNT;
                  tmr_q   <= '0;
               end else begin
                  tmr_q <= tmr_q + TMR_W'(1);
               end
            end
            COUNT: begin
               if (tmr_q == TMR_W'(WINDOW - 1)) begin
                  state_q <= DONE;
                  ro_en_q <= 1'b0;
               end else begin
                  tmr_q <= tmr_q + TMR_W'(1);
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               valid_q <= 1'b1;
               cnt1_q  <= a_cnt;
               cnt2_q  <= b_cnt;
            end
            default: begin
               state_q <= IDLE;
               ro_en_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ro_en       = ro_en_q;
   assign busy        = busy_q;
   assign count1      = cnt1_q;
   assign count2      = cnt2_q;
   assign count_valid = valid_q;

endmodule
